// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/forwarding control with a two-state data-memory handshake FSM.
// Forwarding selects and stall/freeze/flush are combinational; FSM state and counters are registered.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        fwd_en,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic [3:0]  exe_src1,
  input  logic [3:0]  exe_src2,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic [3:0]  exe_dest,
  input  logic        mem_wb_en,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [3:0]  mem_dest,
  input  logic        wb_wb_en,
  input  logic [3:0]  wb_dest,
  input  logic        branch_taken,
  input  logic        sram_ready,
  output logic [1:0]  sel_src1,
  output logic [1:0]  sel_src2,
  output logic        hazard_stall,
  output logic        freeze,
  output logic        flush,
  output logic        sram_req,
  output logic [3:0]  mem_busy_cnt,
  output logic [15:0] stall_cnt
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state;
  logic [3:0]  r_mem_busy_cnt;
  logic [15:0] r_stall_cnt;

  logic w_match_exe, w_match_mem, w_raw, w_access;
  logic w_freeze, w_flush, w_stall;

  // MEM stage is newer than WB, so it wins when both write the same register.
  function automatic logic [1:0] f_sel(input logic en, input logic [3:0] src,
                                       input logic m_wb, input logic [3:0] m_dst,
                                       input logic w_wb, input logic [3:0] w_dst);
    if (en && m_wb && (m_dst == src))      return 2'd1;
    else if (en && w_wb && (w_dst == src)) return 2'd2;
    else                                   return 2'd0;
  endfunction

  assign sel_src1 = f_sel(fwd_en, exe_src1, mem_wb_en, mem_dest, wb_wb_en, wb_dest);
  assign sel_src2 = f_sel(fwd_en, exe_src2, mem_wb_en, mem_dest, wb_wb_en, wb_dest);

  assign w_match_exe = (id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest));
  assign w_match_mem = (id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest));

  // With forwarding only a load-use needs a bubble; without it any pending write does.
  assign w_raw = fwd_en ? (exe_wb_en & exe_mem_r_en & w_match_exe)
                        : ((exe_wb_en & w_match_exe) | (mem_wb_en & w_match_mem));

  assign w_access = mem_r_en | mem_w_en;
  assign w_freeze = ~rst & ((r_state == S_IDLE) ? w_access : ~sram_ready);
  assign w_flush  = ~rst & branch_taken & ~w_freeze;
  assign w_stall  = ~rst & w_raw & ~w_flush;

  assign freeze       = w_freeze;
  assign flush        = w_flush;
  assign hazard_stall = w_stall;
  assign sram_req     = ~rst & (r_state == S_BUSY);
  assign mem_busy_cnt = r_mem_busy_cnt;
  assign stall_cnt    = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_mem_busy_cnt <= 4'd0;
      r_stall_cnt    <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_access) begin
          r_state        <= S_BUSY;
          r_mem_busy_cnt <= 4'd0;
        end
        S_BUSY: begin
          if (sram_ready)                   r_state        <= S_IDLE;
          else if (r_mem_busy_cnt != 4'hF)  r_mem_busy_cnt <= r_mem_busy_cnt + 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_stall && !w_freeze) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fwd_en, id_two_src;
  logic [3:0]  id_src1, id_src2, exe_src1, exe_src2, exe_dest, mem_dest, wb_dest;
  logic        exe_wb_en, exe_mem_r_en, mem_wb_en, mem_r_en, mem_w_en, wb_wb_en;
  logic        branch_taken, sram_ready;
  logic [1:0]  sel_src1, sel_src2;
  logic        hazard_stall, freeze, flush, sram_req;
  logic [3:0]  mem_busy_cnt;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: whether an access is outstanding, busy count, stall count
  bit m_busy;
  int m_cnt;
  int m_stall;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_src1(exe_src1), .exe_src2(exe_src2),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_dest(mem_dest),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
    .branch_taken(branch_taken), .sram_ready(sram_ready),
    .sel_src1(sel_src1), .sel_src2(sel_src2),
    .hazard_stall(hazard_stall), .freeze(freeze), .flush(flush), .sram_req(sram_req),
    .mem_busy_cnt(mem_busy_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int e_sel(input logic [3:0] src);
    if (!fwd_en) return 0;
    if (mem_wb_en && mem_dest == src) return 1;
    if (wb_wb_en && wb_dest == src) return 2;
    return 0;
  endfunction

  function automatic bit uses(input logic [3:0] r);
    return (id_src1 == r) || (id_two_src && id_src2 == r);
  endfunction

  function automatic bit e_freeze();
    if (rst) return 0;
    return m_busy ? !sram_ready : (mem_r_en || mem_w_en);
  endfunction

  function automatic bit e_flush();
    return !rst && branch_taken && !e_freeze();
  endfunction

  function automatic bit e_stall();
    bit raw;
    if (fwd_en) raw = exe_wb_en && exe_mem_r_en && uses(exe_dest);
    else        raw = (exe_wb_en && uses(exe_dest)) || (mem_wb_en && uses(mem_dest));
    return !rst && raw && !e_flush();
  endfunction

  // One cycle: check combinational outputs, clock, advance model, check counters.
  task automatic step();
    bit f, s;
    #1;
    f = e_freeze();
    s = e_stall();
    chk("sel_src1", 32'(sel_src1), 32'(e_sel(exe_src1)));
    chk("sel_src2", 32'(sel_src2), 32'(e_sel(exe_src2)));
    chk("freeze", 32'(freeze), 32'(f));
    chk("flush", 32'(flush), 32'(e_flush()));
    chk("hazard_stall", 32'(hazard_stall), 32'(s));
    chk("sram_req", 32'(sram_req), 32'(!rst && m_busy));
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_cnt = 0; m_stall = 0;
    end else begin
      if (!m_busy) begin
        if (mem_r_en || mem_w_en) begin m_busy = 1; m_cnt = 0; end
      end else if (sram_ready) m_busy = 0;
      else if (m_cnt < 15) m_cnt++;
      if (s && !f) m_stall = (m_stall + 1) % 65536;
    end
    #1;
    chk("mem_busy_cnt", 32'(mem_busy_cnt), 32'(m_cnt));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic idle_inputs();
    rst = 0; fwd_en = 1; id_two_src = 0;
    id_src1 = 4'd1; id_src2 = 4'd2; exe_src1 = 4'd1; exe_src2 = 4'd2;
    exe_wb_en = 0; exe_mem_r_en = 0; exe_dest = 4'd9;
    mem_wb_en = 0; mem_r_en = 0; mem_w_en = 0; mem_dest = 4'd10;
    wb_wb_en = 0; wb_dest = 4'd11; branch_taken = 0; sram_ready = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step();
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_busy_cnt", 32'(mem_busy_cnt), 32'd0);
    rst = 0;

    // forwarding priority
    mem_wb_en = 1; mem_dest = 4'd3; wb_wb_en = 1; wb_dest = 4'd3; exe_src1 = 4'd3;
    #1 chk("fwd_mem", 32'(sel_src1), 32'd1);
    step();
    mem_wb_en = 0;
    #1 chk("fwd_wb", 32'(sel_src1), 32'd2);
    step();
    fwd_en = 0;
    #1 chk("fwd_off", 32'(sel_src1), 32'd0);
    step();
    idle_inputs();

    // load-use on second source
    exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 4'd5; id_src2 = 4'd5; id_two_src = 1;
    #1 chk("loaduse", 32'(hazard_stall), 32'd1);
    step();
    chk("loaduse_cnt", 32'(stall_cnt), 32'd1);
    id_two_src = 0;
    #1 chk("loaduse_one_src", 32'(hazard_stall), 32'd0);
    step();
    idle_inputs();

    // 3 wait cycles, with a taken branch and a hazard waiting behind the freeze
    mem_r_en = 1; branch_taken = 1;
    exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 4'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("acc_freeze", 32'(freeze), 32'd1);
      chk("acc_flush", 32'(flush), 32'd0);
      chk("acc_req", 32'(sram_req), 32'(i != 0));
      step();
    end
    sram_ready = 1;
    #1;
    chk("acc_done_freeze", 32'(freeze), 32'd0);
    chk("acc_done_req", 32'(sram_req), 32'd1);
    chk("acc_done_flush", 32'(flush), 32'd1);
    chk("acc_done_stall", 32'(hazard_stall), 32'd0);
    chk("acc_busy_cnt", 32'(mem_busy_cnt), 32'd3);
    step();
    idle_inputs();
    #1 chk("acc_idle_req", 32'(sram_req), 32'd0);
    step();

    // reset mid-access
    mem_w_en = 1; step(); step();
    rst = 1;
    #1 chk("rst_force_req", 32'(sram_req), 32'd0);
    step();
    rst = 0; mem_w_en = 0;
    #1;
    chk("post_rst_req", 32'(sram_req), 32'd0);
    chk("post_rst_freeze", 32'(freeze), 32'd0);
    chk("post_rst_busy", 32'(mem_busy_cnt), 32'd0);
    chk("post_rst_stall", 32'(stall_cnt), 32'd0);
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 49) == 0);
      fwd_en       = 1'($urandom);
      id_two_src   = 1'($urandom);
      id_src1      = 4'($urandom_range(0, 3));
      id_src2      = 4'($urandom_range(0, 3));
      exe_src1     = 4'($urandom_range(0, 3));
      exe_src2     = 4'($urandom_range(0, 3));
      exe_dest     = 4'($urandom_range(0, 3));
      mem_dest     = 4'($urandom_range(0, 3));
      wb_dest      = 4'($urandom_range(0, 3));
      exe_wb_en    = 1'($urandom);
      exe_mem_r_en = 1'($urandom);
      mem_wb_en    = 1'($urandom);
      wb_wb_en     = 1'($urandom);
      mem_r_en     = ($urandom_range(0, 3) == 0);
      mem_w_en     = ($urandom_range(0, 5) == 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      sram_ready   = ($urandom_range(0, 2) == 0);
      step();
    end

    // counter wrap
    idle_inputs();
    rst = 1; step(); rst = 0;
    exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 4'd1;
    for (int i = 0; i < 65535; i++) step();
    chk("wrap_full", 32'(stall_cnt), 32'hFFFF);
    step();
    chk("wrap_zero", 32'(stall_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
